mrcontrol_seq: RTL and testbench

MRCONTROL_SEQ -- requirements
Module: mrcontrol_seq

---
 rtl/mrcontrol_pkg.sv | 32 +++
 rtl/mrcontrol_cond.sv | 32 +++
 rtl/mrcontrol_seq.sv | 110 +++++++++++
 tb/tb_mrcontrol_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mrcontrol_pkg.sv
// Shared definitions for the micro-sequencer: state encoding, jump condition
// codes, destination region codes and instruction field positions.
package mrcontrol_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_EXEC = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [2:0] COND_NEVER   = 3'd0;
  localparam logic [2:0] COND_ALWAYS  = 3'd1;
  localparam logic [2:0] COND_ZERO    = 3'd2;
  localparam logic [2:0] COND_NONZERO = 3'd3;
  localparam logic [2:0] COND_ODD     = 3'd4;
  localparam logic [2:0] COND_NEG     = 3'd5;

  // Top two bits of the destination address select the store strobe
  localparam logic [1:0] REGION_REG = 2'b00;
  localparam logic [1:0] REGION_ALU = 2'b01;
  localparam logic [1:0] REGION_IO  = 2'b10;
  localparam logic [1:0] REGION_RAM = 2'b11;

  localparam int MOVI_BIT = 0;
  localparam int HALT_BIT = 1;
  localparam int COND_LSB = 2;
  localparam int COND_MSB = 4;

endpackage

// File: rtl/mrcontrol_cond.sv
// Combinational jump-condition evaluator: decodes the COND field of the
// instruction against the accumulator.
module mrcontrol_cond
  import mrcontrol_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] ALU_ACC,
  output logic             taken
);

  logic [2:0] cond;
  logic       unused_bits;

  assign cond        = I[COND_MSB:COND_LSB];
  assign unused_bits = ^{I[WIDTH-1:COND_MSB+1], I[COND_LSB-1:0]};

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NEVER:   taken = 1'b0;
      COND_ALWAYS:  taken = 1'b1;
      COND_ZERO:    taken = (ALU_ACC == '0);
      COND_NONZERO: taken = (ALU_ACC != '0);
      COND_ODD:     taken = ALU_ACC[0];
      COND_NEG:     taken = ALU_ACC[WIDTH-1];
      default:      taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mrcontrol_seq.sv
// Micro-sequencer: fetch (T1), operand (T2), destination (T3) and execute
// phases over a ready-handshaked bus, with HALT exited only by reset.
module mrcontrol_seq
  import mrcontrol_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PC_ADDR  = 64,
  parameter int IMM_ADDR = 72,
  parameter int IDLE_SRC = 129
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             RDY,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] ALU_ACC,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] DST,
  output logic [WIDTH-1:0] SRC,
  output logic             STO_RAM,
  output logic             STO_REG,
  output logic             STO_ALU,
  output logic             STO_IO,
  output logic             J,
  output logic             PC_E,
  output logic             HALTED,
  output logic [2:0]       PHASE
);

  localparam logic [WIDTH-1:0] PC_W   = WIDTH'(PC_ADDR);
  localparam logic [WIDTH-1:0] IMM_W  = WIDTH'(IMM_ADDR);
  localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(IDLE_SRC);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] src_reg, dst_reg;
  logic             taken;

  mrcontrol_cond #(.WIDTH(WIDTH)) u_cond (
    .I      (I),
    .ALU_ACC(ALU_ACC),
    .taken  (taken)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_T2 && RDY) src_reg <= D_IN;
      if (state_reg == ST_T3 && RDY) dst_reg <= D_IN;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (RUN) state_next = ST_T1;
      ST_T1:   if (RDY) state_next = ST_T2;
      ST_T2:   if (RDY) state_next = ST_T3;
      ST_T3:   if (RDY) state_next = ST_EXEC;
      ST_EXEC: if (RDY) state_next = I[HALT_BIT] ? ST_HALT : ST_T1;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes and J are level outputs, so a stall simply keeps them asserted
  always_comb begin
    DST     = '0;
    SRC     = IDLE_W;
    STO_RAM = 1'b0;
    STO_REG = 1'b0;
    STO_ALU = 1'b0;
    STO_IO  = 1'b0;
    J       = 1'b0;
    PC_E    = 1'b0;
    case (state_reg)
      ST_T1: begin
        DST     = PC_W;
        STO_REG = 1'b1;
        PC_E    = RDY;
      end
      ST_T2: begin
        DST     = IMM_W;
        STO_REG = I[MOVI_BIT];
        PC_E    = RDY;
      end
      ST_T3: PC_E = RDY;
      ST_EXEC: begin
        DST = dst_reg;
        SRC = I[MOVI_BIT] ? IMM_W : src_reg;
        case (dst_reg[WIDTH-1:WIDTH-2])
          REGION_REG: STO_REG = 1'b1;
          REGION_ALU: STO_ALU = 1'b1;
          REGION_IO:  STO_IO  = 1'b1;
          default:    STO_RAM = 1'b1;
        endcase
        J    = taken;
        PC_E = taken;
      end
      default: ;
    endcase
  end

  assign HALTED = (state_reg == ST_HALT);
  assign PHASE  = state_reg;

endmodule

// File: tb/tb_mrcontrol_seq.sv
// Self-checking bench for mrcontrol_seq: expected execute-phase results are
// queued at issue time and compared when the DUT completes EXEC.
module tb_mrcontrol_seq #(
  parameter int W = 16
);

  logic         CLK = 1'b0;
  logic         RST, RUN, RDY;
  logic [W-1:0] I, ALU_ACC, D_IN, DST, SRC;
  logic         STO_RAM, STO_REG, STO_ALU, STO_IO, J, PC_E, HALTED;
  logic [2:0]   PHASE;
  logic [3:0]   sto;

  typedef struct {
    logic [W-1:0] instr;
    logic [W-1:0] src;
    logic [W-1:0] dst;
    logic [3:0]   sto;
    logic         j;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  mrcontrol_seq #(.WIDTH(W), .PC_ADDR(64), .IMM_ADDR(72), .IDLE_SRC(129)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .RDY(RDY), .I(I), .ALU_ACC(ALU_ACC),
    .D_IN(D_IN), .DST(DST), .SRC(SRC), .STO_RAM(STO_RAM), .STO_REG(STO_REG),
    .STO_ALU(STO_ALU), .STO_IO(STO_IO), .J(J), .PC_E(PC_E), .HALTED(HALTED),
    .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  assign sto = {STO_RAM, STO_REG, STO_ALU, STO_IO};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic cond_model(input logic [2:0] c, input logic [W-1:0] acc);
    case (c)
      3'd1:    return 1'b1;
      3'd2:    return acc == '0;
      3'd3:    return acc != '0;
      3'd4:    return acc[0];
      3'd5:    return acc[W-1];
      default: return 1'b0;
    endcase
  endfunction

  // Strobe vector order: {RAM, REG, ALU, IO}
  function automatic logic [3:0] sto_model(input logic [1:0] region);
    case (region)
      2'b00:   return 4'b0100;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [W-1:0] mk_dst(input logic [1:0] region, input logic [W-1:0] low);
    logic [W-1:0] v;
    v = low;
    v[W-1 -: 2] = region;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag, input logic [2:0] exp_phase);
    check({tag, "_phase"}, PHASE, exp_phase);
    check({tag, "_dst"}, DST, 0);
    check({tag, "_src"}, SRC, 129);
    check({tag, "_sto"}, sto, 4'b0000);
    check({tag, "_j"}, J, 0);
    check({tag, "_pce"}, PC_E, 0);
    check({tag, "_halted"}, HALTED, (exp_phase == 3'd5) ? 1 : 0);
  endtask

  // Issues one instruction from T1 through EXEC, stalling EXEC for 'stall' cycles
  task automatic run_instr(input logic [W-1:0] instr, input logic [W-1:0] acc,
                           input logic [W-1:0] src_val, input logic [W-1:0] dst_val,
                           input int stall);
    exp_t e;
    e.instr = instr;
    e.src   = instr[0] ? W'(72) : src_val;
    e.dst   = dst_val;
    e.sto   = sto_model(dst_val[W-1 -: 2]);
    e.j     = cond_model(instr[4:2], acc);
    sb.push_back(e);
    I = instr; ALU_ACC = acc; RDY = 1'b1; RUN = 1'b1; D_IN = W'($urandom);
    for (int k = 0; k < 8 && PHASE != 3'd1; k++) step();
    check("reach_t1", PHASE, 3'd1);
    check("t1_dst", DST, 64);
    check("t1_src", SRC, 129);
    check("t1_sto", sto, 4'b0100);
    check("t1_pce", PC_E, 1);
    check("t1_j", J, 0);
    step();
    D_IN = src_val;
    check("t2_phase", PHASE, 3'd2);
    check("t2_dst", DST, 72);
    check("t2_sto", sto, {1'b0, instr[0], 2'b00});
    step();
    D_IN = dst_val;
    check("t3_phase", PHASE, 3'd3);
    check("t3_dst", DST, 0);
    check("t3_sto", sto, 4'b0000);
    check("t3_pce", PC_E, 1);
    step();
    D_IN = W'($urandom);
    if (stall > 0) RDY = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_phase", PHASE, 3'd4);
      check("stall_sto", sto, e.sto);
      check("stall_dst", DST, e.dst);
      check("stall_src", SRC, e.src);
      check("stall_j", J, e.j);
      step();
    end
    RDY = 1'b1;
    step();
  endtask

  // Scoreboard monitor: one pop per completing EXEC cycle
  always @(negedge CLK) begin
    if (RST === 1'b1 && PHASE == 3'd4 && RDY === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("exec_src", SRC, mon_e.src);
        check("exec_dst", DST, mon_e.dst);
        check("exec_sto", sto, mon_e.sto);
        check("exec_j", J, mon_e.j);
        check("exec_pce", PC_E, mon_e.j);
        n_txn++;
        $display("txn %0d: I=%0h SRC=%0h DST=%0h sto=%b J=%b PC_E=%b",
                 n_txn, mon_e.instr, SRC, DST, sto, J, PC_E);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] msb;
    logic [W-1:0] instr;
    logic [W-1:0] acc;
    msb = '0;
    msb[W-1] = 1'b1;
    RST = 1'b0; RUN = 1'b0; RDY = 1'b0;
    I = '0; ALU_ACC = '0; D_IN = '0;
    step(); step();
    check_idle_outputs("reset", 3'd0);
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_hold", PHASE, 3'd0);
    end

    run_instr(W'(0), W'(0), W'(5), W'(16'h0103), 0);
    check("move_back_to_t1", PHASE, 3'd1);
    run_instr(W'(1), W'(0), W'(16'h1234), mk_dst(2'b11, W'(16'h0010)), 0);
    run_instr(W'(8), W'(0), W'($urandom), mk_dst(2'b01, W'(3)), 0);
    run_instr(W'(8), W'(1), W'($urandom), mk_dst(2'b01, W'(4)), 0);
    run_instr(W'(0), W'(7), W'(9), mk_dst(2'b10, W'(5)), 3);
    check("stall_advance", PHASE, 3'd1);

    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        acc = (k == 0) ? '0 : (k == 1) ? W'(1) : (k == 2) ? msb : W'($urandom);
        instr = W'($urandom);
        instr[1] = 1'b0;
        instr[4:2] = 3'(c);
        run_instr(instr, acc, W'($urandom), W'($urandom), $urandom_range(0, 2));
      end
    end

    run_instr(W'(2), W'(0), W'(11), W'(16'h0022), 1);
    check_idle_outputs("halt", 3'd5);
    for (int k = 0; k < 20; k++) begin
      RUN = 1'($urandom); RDY = 1'($urandom);
      step();
      check("halt_stay", PHASE, 3'd5);
      check("halt_flag", HALTED, 1);
    end

    #2 RST = 1'b0;
    #1 check_idle_outputs("reset_from_halt", 3'd0);
    step();
    RUN = 1'b0; RDY = 1'b1; RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("restart_needs_run", PHASE, 3'd0);
    end

    RUN = 1'b1; I = '0; D_IN = W'(16'h00C0);
    step();
    check("restart_t1", PHASE, 3'd1);
    step(); step();
    RDY = 1'b0;
    step(); step();
    check("t3_stalled", PHASE, 3'd3);
    #2 RST = 1'b0;
    #1 check_idle_outputs("reset_mid_t3", 3'd0);
    step();
    RUN = 1'b0; RDY = 1'b1; RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_idle", PHASE, 3'd0);
      check("abort_sto", sto, 4'b0000);
    end

    run_instr(W'(6), W'(0), W'(13), mk_dst(2'b01, W'(1)), 2);
    check("halt_jump_phase", PHASE, 3'd5);
    check("halt_jump_halted", HALTED, 1);

    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
